bht_controller: RTL and testbench

//  Bimodal branch-history-table controller for the pipelined core's predictor.

---
 rtl/bht_controller.sv | 139 +++++++++++++
 tb/tb_bht_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bht_controller.sv
// Bimodal branch-history-table controller: init sweep, combinational fetch lookup,
// and a 2-stage read-modify-write update pipe with forwarding and lookup bypass.

module saturated_adder #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             taken_i,
  output logic [WIDTH-1:0] val_o
);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // Count up on taken, down on not-taken, clamping at both ends.
  always_comb begin
    val_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != MAX_VAL) val_o = cnt_i + WIDTH'(1);
    end else begin
      if (cnt_i != '0) val_o = cnt_i - WIDTH'(1);
    end
  end
endmodule

module bht_controller #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] pc_f_i,
  output logic        pred_taken_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  output logic        ready_o
);
  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam logic [CNT_WIDTH-1:0]  INIT_VAL = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   init_idx_q, init_idx_d;
  logic [CNT_WIDTH-1:0]    table_q [DEPTH];

  logic                    s1_valid_q;
  logic [INDEX_BITS-1:0]   s1_idx_q;
  logic                    s1_taken_q;
  logic [CNT_WIDTH-1:0]    s1_cnt_q;
  logic [CNT_WIDTH-1:0]    val;

  logic [INDEX_BITS-1:0]   f_idx, u_idx, wr_idx;
  logic [CNT_WIDTH-1:0]    wr_val;
  logic                    wr_en, s0_fire, s1_write, fwd;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f_i[31:INDEX_BITS+2], pc_f_i[1:0],
                            upd_pc_i[31:INDEX_BITS+2], upd_pc_i[1:0]};

  assign f_idx = pc_f_i[INDEX_BITS+1:2];
  assign u_idx = upd_pc_i[INDEX_BITS+1:2];

  saturated_adder #(.WIDTH(CNT_WIDTH)) u_sat (
    .cnt_i   (s1_cnt_q),
    .taken_i (s1_taken_q),
    .val_o   (val)
  );

  // Next state, sweep index and the single table write port; flush wins over updates.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    wr_en      = 1'b0;
    wr_idx     = s1_idx_q;
    wr_val     = val;
    s0_fire    = 1'b0;
    s1_write   = 1'b0;
    case (state_q)
      INIT: begin
        wr_en      = 1'b1;
        wr_idx     = init_idx_q;
        wr_val     = INIT_VAL;
        init_idx_d = init_idx_q + INDEX_BITS'(1);
        if (flush_i)                      init_idx_d = '0;
        else if (init_idx_q == LAST_IDX)  state_d    = RUN;
      end
      RUN: begin
        if (flush_i) begin
          state_d    = INIT;
          init_idx_d = '0;
        end else begin
          s1_write = s1_valid_q;
          wr_en    = s1_valid_q;
          s0_fire  = upd_valid_i;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign fwd = s1_write && (s1_idx_q == u_idx);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      ready_o    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_taken_q <= 1'b0;
      s1_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ready_o    <= (state_d == RUN);
      s1_valid_q <= s0_fire;
      if (s0_fire) begin
        s1_idx_q   <= u_idx;
        s1_taken_q <= upd_taken_i;
        s1_cnt_q   <= fwd ? val : table_q[u_idx];
      end
    end
  end

  // Counter storage carries no reset; the sweep defines its contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) table_q[wr_idx] <= wr_val;
  end

  always_comb begin
    pred_taken_o = 1'b0;
    if (state_q == RUN) begin
      if (s1_write && (s1_idx_q == f_idx)) pred_taken_o = val[CNT_WIDTH-1];
      else                                 pred_taken_o = table_q[f_idx][CNT_WIDTH-1];
    end
  end
endmodule

// File: tb/tb_bht_controller.sv
// Scoreboard bench for bht_controller: a reference counter table predicts every
// lookup and ready flag; expectations are queued at drive time and popped at sample time.

module tb_bht_controller;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [31:0] pc_f_i;
  logic        pred_taken_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        ready_o;

  always #5 clk_i = ~clk_i;

  bht_controller #(.INDEX_BITS(6), .CNT_WIDTH(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .pc_f_i       (pc_f_i),
    .pred_taken_o (pred_taken_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .ready_o      (ready_o)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [1:0]  model [64];
  int          m_init;
  logic        exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model[i] = 2'b01;
    m_init = 64;
  endtask

  // One clock: drive, queue the expectation, sample mid-cycle, then advance the model.
  task automatic cycle(input logic fl, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] fpc, input string tag);
    logic exp_rdy, exp_pred;
    logic [5:0] fi, ui;
    fi = fpc[7:2];
    ui = upc[7:2];
    flush_i = fl; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; pc_f_i = fpc;
    exp_rdy  = (m_init == 0);
    exp_pred = exp_rdy ? model[fi][1] : 1'b0;
    exp_q.push_back(exp_pred);
    #1;
    check_val({tag, "_rdy"}, 32'(ready_o), 32'(exp_rdy));
    check_val({tag, "_pred"}, 32'(pred_taken_o), 32'(exp_q.pop_front()));
    @(posedge clk_i);
    #1;
    if (fl)              model_clear();
    else if (m_init > 0) m_init--;
    else if (uv)         model[ui] = sat(model[ui], ut);
  endtask

  task automatic idle(input logic [31:0] fpc, input string tag);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, fpc, tag);
  endtask

  task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] fpc, input string tag);
    cycle(1'b0, 1'b1, upc, ut, fpc, tag);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    check_val("rst_rdy", 32'(ready_o), 32'd0);
    check_val("rst_pred", 32'(pred_taken_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_clear();
  endtask

  // Sweep window: ready low, predictions forced 0, updates to entry 0 must be dropped.
  task automatic sweep_phase(input int n, input string tag);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b1, 32'h0, 1'b1, $urandom, tag);
  endtask

  task automatic check_all_entries(input string tag);
    for (int i = 0; i < 64; i++) idle(32'(i * 4), tag);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; pc_f_i = '0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_rdy", 32'(ready_o), 32'd0);
    check_val("rst_pred", 32'(pred_taken_o), 32'd0);
    rst_i = 1'b0;

    sweep_phase(64, "init");
    check_all_entries("swept");

    // Single taken update, with a same-cycle bypass lookup during S1.
    upd(32'h40, 1'b1, 32'h40, "u40");
    idle(32'h40, "byp40");
    idle(32'h40, "l40");
    idle(32'h44, "l44");

    // Saturation up then back down.
    for (int i = 0; i < 4; i++) upd(32'h80, 1'b1, 32'h80, "sat_up");
    idle(32'h80, "sat_top");
    upd(32'h80, 1'b0, 32'h80, "dn1");
    upd(32'h80, 1'b0, 32'h80, "dn2");
    idle(32'h80, "dn_byp");
    idle(32'h80, "dn_end");

    // Alternating indices, then a forwarded same-index pair and its decay.
    for (int i = 0; i < 4; i++) upd((i % 2) ? 32'h14 : 32'h10, 1'b1, 32'h10, "alt");
    upd(32'h18, 1'b1, 32'h14, "fw1");
    upd(32'h18, 1'b1, 32'h18, "fw2");
    upd(32'h18, 1'b0, 32'h18, "fw3");
    idle(32'h18, "fw_mid");
    upd(32'h18, 1'b0, 32'h18, "fw4");
    idle(32'h18, "fw_end");
    upd(32'h10, 1'b0, 32'h10, "a10d1");
    upd(32'h10, 1'b0, 32'h10, "a10d2");
    idle(32'h10, "a10_end");

    // Random traffic over a few indices to exercise forwarding and bypass broadly.
    for (int i = 0; i < 300; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4),
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4), "rnd");

    // Flush while an update sits in S1; flush and update together in the same cycle.
    upd(32'h40, 1'b1, 32'h0, "pre_fl");
    cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h84, "flush");
    sweep_phase(10, "fl_sweep");
    cycle(1'b1, 1'b1, 32'h0, 1'b1, 32'h0, "fl_restart");
    sweep_phase(64, "fl_sweep2");
    check_all_entries("fl_swept");

    // Reset in the middle of a sweep restarts it from entry 0.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "fl3");
    sweep_phase(20, "pre_rst");
    do_reset();
    sweep_phase(64, "rst_sweep");
    check_all_entries("rst_swept");
    upd(32'h0, 1'b1, 32'h0, "post_u");
    idle(32'h0, "post_l");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
